// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: mode encodings, pattern width,
// mode ordering and per-mode entry patterns.
package led_seq_pkg;

   localparam int PAT_W     = 5;
   localparam int NUM_MODES = 5;

   typedef enum logic [2:0] {
      MODE_OFF    = 3'd0,
      MODE_BLINK  = 3'd1,
      MODE_CHASE  = 3'd2,
      MODE_BOUNCE = 3'd3,
      MODE_COUNT  = 3'd4
   } mode_e;

   // Unused encodings fall back to OFF so a corrupted state self-heals.
   function automatic mode_e next_mode(input mode_e m);
      case (m)
         MODE_OFF:    next_mode = MODE_BLINK;
         MODE_BLINK:  next_mode = MODE_CHASE;
         MODE_CHASE:  next_mode = MODE_BOUNCE;
         MODE_BOUNCE: next_mode = MODE_COUNT;
         default:     next_mode = MODE_OFF;
      endcase
   endfunction

   function automatic logic [PAT_W-1:0] entry_pat(input mode_e m);
      case (m)
         MODE_CHASE, MODE_BOUNCE: entry_pat = PAT_W'(1);
         default:                 entry_pat = '0;
      endcase
   endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Pin-level bundle of the sequencer's button/brightness inputs and LED/mode outputs.
// No handshake: btn and brightness are level inputs sampled every clock; led and mode are registered levels.
interface led_sequencer_if;
   logic       btn;
   logic [3:0] brightness;
   wire  [4:0] led;
   wire  [2:0] mode;

   modport master (output btn, output brightness, input led, input mode);
   modport slave  (input btn, input brightness, output led, output mode);
endinterface

// File: rtl/led_debounce.sv
// Two-flop synchronizer plus counting debouncer; emits a one-cycle pulse on
// each accepted rising edge of the debounced level.
module led_debounce #(
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic hwclk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise
);

   localparam int              CW   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync0;
   logic          r_sync1;
   logic          r_level;
   logic          r_rise;
   logic [CW-1:0] r_cnt;

   // Any sample equal to the current level restarts the stability count.
   always_ff @(posedge hwclk) begin
      if (rst) begin
         r_sync0 <= 1'b0;
         r_sync1 <= 1'b0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync0 <= din;
         r_sync1 <= r_sync0;
         r_rise  <= 1'b0;
         if (r_sync1 != r_level) begin
            if (r_cnt == LAST) begin
               r_level <= r_sync1;
               r_rise  <= r_sync1;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign level = r_level;
   assign rise  = r_rise;

endmodule

// File: rtl/led_sequencer.sv
// Button-driven five-LED pattern sequencer with step prescaler and 16-level PWM dimming.
module led_sequencer
   import led_seq_pkg::*;
#(
   parameter int STEP_DIV        = 262144,
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic       hwclk,
   input  logic       rst,
   input  logic       btn,
   input  logic [3:0] brightness,
   output logic       led1,
   output logic       led2,
   output logic       led3,
   output logic       led4,
   output logic       led5,
   output logic [2:0] mode
);

   localparam int            PW        = $clog2(STEP_DIV);
   localparam logic [PW-1:0] STEP_LAST = PW'(STEP_DIV - 1);

   logic             w_adv;
   logic             w_level_unused;
   logic             w_step;
   logic             w_on;
   mode_e            r_mode;
   logic [PAT_W-1:0] r_pat;
   logic             r_dir_right;
   logic [PW-1:0]    r_presc;
   logic [3:0]       r_pwm_cnt;
   logic [3:0]       r_bright_q;
   logic [PAT_W-1:0] r_led;

   led_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .hwclk (hwclk),
      .rst   (rst),
      .din   (btn),
      .level (w_level_unused),
      .rise  (w_adv)
   );

   assign w_step = (r_presc == STEP_LAST);

   // adv has priority: it reloads the entry pattern and swallows a coincident step.
   always_ff @(posedge hwclk) begin
      if (rst) begin
         r_mode      <= MODE_OFF;
         r_pat       <= '0;
         r_dir_right <= 1'b0;
         r_presc     <= '0;
      end else if (w_adv) begin
         r_mode      <= next_mode(r_mode);
         r_pat       <= entry_pat(next_mode(r_mode));
         r_dir_right <= 1'b0;
         r_presc     <= '0;
      end else begin
         r_presc <= w_step ? '0 : r_presc + 1'b1;
         case (r_mode)
            MODE_OFF: begin
               if (w_step) r_pat <= '0;
            end
            MODE_BLINK: begin
               if (w_step) r_pat <= ~r_pat;
            end
            MODE_CHASE: begin
               if (w_step) r_pat <= {r_pat[PAT_W-2:0], r_pat[PAT_W-1]};
            end
            MODE_BOUNCE: begin
               // Direction flips on the step that lands on an end bit.
               if (w_step) begin
                  if (!r_dir_right) begin
                     r_pat <= r_pat << 1;
                     if (r_pat[PAT_W-2]) r_dir_right <= 1'b1;
                  end else begin
                     r_pat <= r_pat >> 1;
                     if (r_pat[1]) r_dir_right <= 1'b0;
                  end
               end
            end
            MODE_COUNT: begin
               if (w_step) r_pat <= r_pat + 1'b1;
            end
            default: begin
               r_mode      <= MODE_OFF;
               r_pat       <= '0;
               r_dir_right <= 1'b0;
            end
         endcase
      end
   end

   assign w_on = (r_pwm_cnt < r_bright_q);

   // Brightness is only picked up at the window boundary so a duty never tears mid-window.
   always_ff @(posedge hwclk) begin
      if (rst) begin
         r_pwm_cnt  <= '0;
         r_bright_q <= '0;
         r_led      <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
         if (r_pwm_cnt == 4'hF) r_bright_q <= brightness;
         r_led <= r_pat & {PAT_W{w_on}};
      end
   end

   assign led1 = r_led[0];
   assign led2 = r_led[1];
   assign led3 = r_led[2];
   assign led4 = r_led[3];
   assign led5 = r_led[4];
   assign mode = r_mode;

endmodule
